// File: rtl/spi_ram_master_if.sv
// Host-side request/response bundle for spi_ram_master.
// master modport: host that issues commands; slave modport: the SPI master block.
interface spi_ram_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       cmd_err;
  logic       busy;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, cmd_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, cmd_err, busy
  );
endinterface

// File: rtl/spi_ram_master.sv
// SPI master for the 10-bit command protocol of the SPI-slave/RAM subsystem.
// Frame: one start cycle carrying op[1], then {op,data} MSB first; read-data
// frames then wait RD_WAIT cycles and capture 8 MISO bits MSB first.
module spi_ram_master #(
  parameter int unsigned RD_WAIT  = 2,
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_ram_master_if.slave    host,
  output logic               SS_n,
  output logic               MOSI,
  input  logic               MISO
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_WAIT,
    ST_CAPTURE,
    ST_GAP
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_LAST  = 4'(IDLE_GAP - 1);

  state_t     state;
  logic [9:0] frame;
  logic [3:0] cnt;
  logic [6:0] cap;
  logic       is_read;
  logic       rd_pending;

  // Frame sequencer; every output is a register updated on the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      frame          <= '0;
      cnt            <= '0;
      cap            <= '0;
      is_read        <= 1'b0;
      rd_pending     <= 1'b0;
      SS_n           <= 1'b1;
      MOSI           <= 1'b0;
      host.cmd_ready <= 1'b1;
      host.busy      <= 1'b0;
      host.rsp_valid <= 1'b0;
      host.rsp_data  <= '0;
      host.cmd_err   <= 1'b0;
    end else begin
      host.rsp_valid <= 1'b0;
      host.cmd_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          // cmd_ready is high throughout IDLE, so cmd_valid alone is an accept.
          if (host.cmd_valid) begin
            if (host.cmd_op == 2'b11 && !rd_pending) begin
              host.cmd_err <= 1'b1;
            end else begin
              frame          <= {host.cmd_op, (host.cmd_op == 2'b11) ? 8'h00 : host.cmd_data};
              is_read        <= (host.cmd_op == 2'b11);
              if (host.cmd_op == 2'b10) rd_pending <= 1'b1;
              state          <= ST_START;
              SS_n           <= 1'b0;
              MOSI           <= host.cmd_op[1];
              host.cmd_ready <= 1'b0;
              host.busy      <= 1'b1;
            end
          end
        end
        ST_START: begin
          MOSI  <= frame[9];
          frame <= {frame[8:0], 1'b0};
          cnt   <= '0;
          state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cnt == 4'd9) begin
            MOSI <= 1'b0;
            cnt  <= '0;
            if (is_read) begin
              state <= ST_WAIT;
            end else begin
              state <= ST_GAP;
              SS_n  <= 1'b1;
            end
          end else begin
            MOSI  <= frame[9];
            frame <= {frame[8:0], 1'b0};
            cnt   <= cnt + 4'd1;
          end
        end
        ST_WAIT: begin
          if (cnt == WAIT_LAST) begin
            cnt   <= '0;
            state <= ST_CAPTURE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_CAPTURE: begin
          cap <= {cap[5:0], MISO};
          if (cnt == 4'd7) begin
            host.rsp_data  <= {cap, MISO};
            host.rsp_valid <= 1'b1;
            rd_pending     <= 1'b0;
            cnt            <= '0;
            state          <= ST_GAP;
            SS_n           <= 1'b1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt            <= '0;
            state          <= ST_IDLE;
            host.cmd_ready <= 1'b1;
            host.busy      <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state          <= ST_IDLE;
          SS_n           <= 1'b1;
          MOSI           <= 1'b0;
          host.cmd_ready <= 1'b1;
          host.busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
